// File: rtl/fpu_32.sv
// Single-precision FPU: add, subtract, multiply, divide and reciprocal with truncating
// rounding and flush-to-zero; result and exception flags are registered every clock.
module fpu_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       OpCode,
  output logic [WIDTH-1:0] Result,
  output logic             Overflow_out,
  output logic             Underflow_out
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] ONE  = 32'h3F80_0000;
  localparam int CNAN  = 2;
  localparam int CINF  = 1;
  localparam int CZERO = 0;

  // {nan, inf, zero}; exponent 0 counts as zero so subnormal inputs vanish
  function automatic logic [2:0] classify(input logic [30:0] v);
    return {(v[30:23] == 8'hFF) && (v[22:0] != 23'd0),
            (v[30:23] == 8'hFF) && (v[22:0] == 23'd0),
            (v[30:23] == 8'h00)};
  endfunction

  // Returns {overflow, underflow, binary32}; saturates to Inf or flushes to signed zero
  function automatic logic [33:0] packNormal(input logic s, input logic signed [10:0] e,
                                             input logic [22:0] f);
    if (e >= 11'sd255) return {2'b10, s, 8'hFF, 23'd0};
    else if (e <= 11'sd0) return {2'b01, s, 31'd0};
    else return {2'b00, s, 8'(e), f};
  endfunction

  logic [2:0]         clsA, clsB, clsX, clsY;
  logic [31:0]        bEff;
  logic [30:0]        addBig, addSmall;
  logic               addSignBig, addSub;
  logic [7:0]         addDiff;
  logic [5:0]         addShift;
  logic [53:0]        addWide;
  logic [27:0]        addSum, addNorm;
  logic [4:0]         addLz;
  logic signed [10:0] addExp;
  logic [33:0]        addPack;
  logic [47:0]        mulProd, mulNorm;
  logic signed [10:0] mulExp;
  logic [33:0]        mulPack;
  logic [31:0]        divX, divY;
  logic [25:0]        divRem, divQ, divNorm;
  logic signed [10:0] divExp;
  logic [33:0]        divPack;
  logic [WIDTH-1:0]   result_d, result_q;
  logic               overflow_d, overflow_q, underflow_d, underflow_q;

  // The lost-bit sticky is subtracted on effective subtraction so the difference is the
  // floor of the exact value, which keeps truncation correct after normalisation.
  always_comb begin
    bEff = {B[31] ^ (OpCode == 3'b001), B[30:0]};
    if (A[30:0] >= bEff[30:0]) begin
      addBig = A[30:0];
      addSmall = bEff[30:0];
      addSignBig = A[31];
    end else begin
      addBig = bEff[30:0];
      addSmall = A[30:0];
      addSignBig = bEff[31];
    end
    addSub = A[31] ^ bEff[31];
    addDiff = addBig[30:23] - addSmall[30:23];
    addShift = (addDiff > 8'd31) ? 6'd31 : 6'(addDiff);
    addWide = {1'b1, addSmall[22:0], 30'd0} >> addShift;
    if (addSub)
      addSum = {2'b01, addBig[22:0], 3'd0} - {1'b0, addWide[53:27]} - 28'(|addWide[26:0]);
    else
      addSum = {2'b01, addBig[22:0], 3'd0} + {1'b0, addWide[53:27]};
    addLz = 5'd0;
    for (int i = 0; i < 28; i++) begin
      if (addSum[i]) addLz = 5'(27 - i);
    end
    addNorm = addSum << addLz;
    addExp = $signed({3'b000, addBig[30:23]}) + 11'sd1 - $signed({6'd0, addLz});
    addPack = packNormal(addSignBig, addExp, 23'(addNorm >> 4));
  end

  always_comb begin
    mulProd = 48'({1'b1, A[22:0]}) * 48'({1'b1, B[22:0]});
    mulNorm = mulProd[47] ? mulProd : mulProd << 1;
    mulExp = $signed({3'b000, A[30:23]}) + $signed({3'b000, B[30:23]}) - 11'sd127
             + $signed({10'd0, mulProd[47]});
    mulPack = packNormal(A[31] ^ B[31], mulExp, 23'(mulNorm >> 24));
  end

  // Reciprocals reuse the divider with a 1.0 dividend; 26 restoring steps give the
  // 24 significand bits plus one bit of headroom for a quotient below 1.0.
  always_comb begin
    divX = (OpCode == 3'b011) ? A : ONE;
    divY = (OpCode == 3'b100) ? A : B;
    divRem = {2'b01, divX[22:0]};
    divQ = '0;
    for (int i = 25; i >= 0; i--) begin
      if (divRem >= {2'b01, divY[22:0]}) begin
        divQ[i] = 1'b1;
        divRem = divRem - {2'b01, divY[22:0]};
      end
      divRem = divRem << 1;
    end
    divNorm = divQ[25] ? divQ : divQ << 1;
    divExp = $signed({3'b000, divX[30:23]}) - $signed({3'b000, divY[30:23]}) + 11'sd126
             + $signed({10'd0, divQ[25]});
    divPack = packNormal(divX[31] ^ divY[31], divExp, 23'(divNorm >> 2));
  end

  always_comb begin
    clsA = classify(A[30:0]);
    clsB = classify(B[30:0]);
    clsX = classify(divX[30:0]);
    clsY = classify(divY[30:0]);
    result_d = '0;
    overflow_d = 1'b0;
    underflow_d = 1'b0;
    case (OpCode)
      3'b000, 3'b001: begin
        if (clsA[CNAN] || clsB[CNAN]) result_d = QNAN;
        else if (clsA[CINF] && clsB[CINF]) result_d = (A[31] == bEff[31]) ? A : QNAN;
        else if (clsA[CINF]) result_d = A;
        else if (clsB[CINF]) result_d = bEff;
        else if (clsA[CZERO] && clsB[CZERO]) result_d = '0;
        else if (clsA[CZERO]) result_d = bEff;
        else if (clsB[CZERO]) result_d = A;
        else if (addSum == 28'd0) result_d = '0;
        else {overflow_d, underflow_d, result_d} = addPack;
      end
      3'b010: begin
        if (clsA[CNAN] || clsB[CNAN]) result_d = QNAN;
        else if ((clsA[CZERO] && clsB[CINF]) || (clsA[CINF] && clsB[CZERO])) result_d = QNAN;
        else if (clsA[CINF] || clsB[CINF]) result_d = {A[31] ^ B[31], 8'hFF, 23'd0};
        else if (clsA[CZERO] || clsB[CZERO]) result_d = {A[31] ^ B[31], 31'd0};
        else {overflow_d, underflow_d, result_d} = mulPack;
      end
      3'b011, 3'b100, 3'b101: begin
        if (clsX[CNAN] || clsY[CNAN]) result_d = QNAN;
        else if ((clsX[CZERO] && clsY[CZERO]) || (clsX[CINF] && clsY[CINF])) result_d = QNAN;
        else if (clsY[CZERO] || clsX[CINF]) result_d = {divX[31] ^ divY[31], 8'hFF, 23'd0};
        else if (clsY[CINF] || clsX[CZERO]) result_d = {divX[31] ^ divY[31], 31'd0};
        else {overflow_d, underflow_d, result_d} = divPack;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      result_q <= '0;
      overflow_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      result_q <= result_d;
      overflow_q <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign Result = result_q;
  assign Overflow_out = overflow_q;
  assign Underflow_out = underflow_q;

endmodule

// File: tb/tb_fpu_32.sv
// Testbench for fpu_32: directed corner vectors plus randomized operations checked
// against an exact-integer model of truncating binary32 arithmetic.
module tb_fpu_32;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] ONE  = 32'h3F80_0000;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
    logic        uf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] A, B;
  logic [2:0]  OpCode;
  logic [31:0] Result;
  logic        Overflow_out, Underflow_out;
  int          errors = 0;
  int          checks = 0;

  fpu_32 #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .OpCode(OpCode),
    .Result(Result), .Overflow_out(Overflow_out), .Underflow_out(Underflow_out)
  );

  always #5 clk = ~clk;

  function automatic logic fpNan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  function automatic logic fpInf(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] == 23'd0);
  endfunction

  function automatic logic fpZero(input logic [31:0] v);
    return v[30:23] == 8'h00;
  endfunction

  // Value is mag * 2^e2 exactly (mag nonzero); truncate it to binary32 -> {ovf, uf, bits}
  function automatic logic [33:0] modelRound(input logic s, input logic [511:0] mag, input int e2);
    int p;
    int be;
    logic [511:0] f;
    p = 0;
    for (int i = 0; i < 512; i++) if (mag[i]) p = i;
    be = p + e2 + 127;
    if (be >= 255) return {2'b10, s, 8'hFF, 23'd0};
    if (be <= 0) return {2'b01, s, 31'd0};
    if (p >= 23) f = mag >> (p - 23);
    else f = mag << (23 - p);
    return {2'b00, s, 8'(be), 23'(f)};
  endfunction

  function automatic logic [33:0] modelAdd(input logic [31:0] a, input logic [31:0] b);
    logic [511:0] ma, mb, mag;
    logic s;
    if (fpNan(a) || fpNan(b)) return {2'b00, QNAN};
    if (fpInf(a) && fpInf(b)) return {2'b00, (a[31] == b[31]) ? a : QNAN};
    if (fpInf(a)) return {2'b00, a};
    if (fpInf(b)) return {2'b00, b};
    ma = fpZero(a) ? '0 : (512'({1'b1, a[22:0]}) << (int'(a[30:23]) - 1));
    mb = fpZero(b) ? '0 : (512'({1'b1, b[22:0]}) << (int'(b[30:23]) - 1));
    if (a[31] == b[31]) begin mag = ma + mb; s = a[31]; end
    else if (ma > mb) begin mag = ma - mb; s = a[31]; end
    else begin mag = mb - ma; s = b[31]; end
    if (mag == '0) return 34'd0;
    return modelRound(s, mag, -149);
  endfunction

  function automatic logic [33:0] modelMul(input logic [31:0] a, input logic [31:0] b);
    logic s;
    s = a[31] ^ b[31];
    if (fpNan(a) || fpNan(b)) return {2'b00, QNAN};
    if ((fpZero(a) && fpInf(b)) || (fpInf(a) && fpZero(b))) return {2'b00, QNAN};
    if (fpInf(a) || fpInf(b)) return {2'b00, s, 8'hFF, 23'd0};
    if (fpZero(a) || fpZero(b)) return {2'b00, s, 31'd0};
    return modelRound(s, 512'({1'b1, a[22:0]}) * 512'({1'b1, b[22:0]}),
                      int'(a[30:23]) + int'(b[30:23]) - 300);
  endfunction

  function automatic logic [33:0] modelDiv(input logic [31:0] x, input logic [31:0] y);
    logic s;
    s = x[31] ^ y[31];
    if (fpNan(x) || fpNan(y)) return {2'b00, QNAN};
    if ((fpZero(x) && fpZero(y)) || (fpInf(x) && fpInf(y))) return {2'b00, QNAN};
    if (fpZero(y) || fpInf(x)) return {2'b00, s, 8'hFF, 23'd0};
    if (fpInf(y) || fpZero(x)) return {2'b00, s, 31'd0};
    return modelRound(s, (512'({1'b1, x[22:0]}) << 64) / 512'({1'b1, y[22:0]}),
                      int'(x[30:23]) - int'(y[30:23]) - 64);
  endfunction

  function automatic logic [33:0] modelOp(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      3'b000: return modelAdd(a, b);
      3'b001: return modelAdd(a, {~b[31], b[30:0]});
      3'b010: return modelMul(a, b);
      3'b011: return modelDiv(a, b);
      3'b100: return modelDiv(ONE, a);
      3'b101: return modelDiv(ONE, b);
      default: return 34'd0;
    endcase
  endfunction

  // Biased toward zeros, infinities, NaNs and extreme exponents
  function automatic logic [31:0] randOperand();
    logic [31:0] v;
    int kind;
    v = $urandom;
    kind = $urandom_range(0, 11);
    case (kind)
      0: v[30:23] = 8'd0;
      1: v[30:0] = {8'hFF, 23'd0};
      2: v[30:23] = 8'hFF;
      3: v[30:23] = 8'(250 + $urandom_range(0, 4));
      4: v[30:23] = 8'(1 + $urandom_range(0, 4));
      5: v[30:23] = 8'(120 + $urandom_range(0, 14));
      default: if (v[30:23] == 8'd0 || v[30:23] == 8'hFF) v[30:23] = 8'd127;
    endcase
    return v;
  endfunction

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    OpCode = op;
    A = a;
    B = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    A = '0;
    B = '0;
    OpCode = 3'b000;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (Result !== 32'd0 || Overflow_out !== 1'b0 || Underflow_out !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset[%0d]: got %h ovf=%b uf=%b, expected 00000000 ovf=0 uf=0",
                 i, Result, Overflow_out, Underflow_out);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(3'b010, 32'h7F00_0000, 32'h4000_0000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (Result !== 32'd0 || Overflow_out !== 1'b0 || Underflow_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_after_overflow: got %h ovf=%b uf=%b, expected 00000000 ovf=0 uf=0",
               Result, Overflow_out, Underflow_out);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_add;
    vec_t v[5];
    v[0] = '{3'b000, 32'h4000_0000, 32'h4040_0000, 32'h40A0_0000, 1'b0, 1'b0};
    v[1] = '{3'b000, 32'h7F80_0000, 32'h4040_0000, 32'h7F80_0000, 1'b0, 1'b0};
    v[2] = '{3'b000, 32'hFF80_0000, 32'h7F80_0000, 32'h7FC0_0000, 1'b0, 1'b0};
    v[3] = '{3'b000, 32'h0000_0001, 32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0};
    v[4] = '{3'b000, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(v[i].op, v[i].a, v[i].b);
      checks++;
      if (Result !== v[i].res || Overflow_out !== v[i].ovf || Underflow_out !== v[i].uf) begin
        errors++;
        $display("[TB] FAIL add[%0d]: got %h ovf=%b uf=%b, expected %h ovf=%b uf=%b",
                 i, Result, Overflow_out, Underflow_out, v[i].res, v[i].ovf, v[i].uf);
      end
    end
  endtask

  task automatic test_sub;
    vec_t v[4];
    v[0] = '{3'b001, 32'h40A0_0000, 32'h4040_0000, 32'h4000_0000, 1'b0, 1'b0};
    v[1] = '{3'b001, 32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 1'b0, 1'b0};
    v[2] = '{3'b001, 32'hBF80_0000, 32'hBF80_0000, 32'h0000_0000, 1'b0, 1'b0};
    v[3] = '{3'b001, 32'h3F80_0000, 32'h3380_0000, 32'h3F7F_FFFF, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(v[i].op, v[i].a, v[i].b);
      checks++;
      if (Result !== v[i].res || Overflow_out !== v[i].ovf || Underflow_out !== v[i].uf) begin
        errors++;
        $display("[TB] FAIL sub[%0d]: got %h ovf=%b uf=%b, expected %h ovf=%b uf=%b",
                 i, Result, Overflow_out, Underflow_out, v[i].res, v[i].ovf, v[i].uf);
      end
    end
  endtask

  task automatic test_mul;
    vec_t v[5];
    v[0] = '{3'b010, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b0, 1'b0};
    v[1] = '{3'b010, 32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000, 1'b0, 1'b0};
    v[2] = '{3'b010, 32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 1'b1, 1'b0};
    v[3] = '{3'b010, 32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 1'b0, 1'b0};
    v[4] = '{3'b010, 32'h0080_0000, 32'hBF00_0000, 32'h8000_0000, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(v[i].op, v[i].a, v[i].b);
      checks++;
      if (Result !== v[i].res || Overflow_out !== v[i].ovf || Underflow_out !== v[i].uf) begin
        errors++;
        $display("[TB] FAIL mul[%0d]: got %h ovf=%b uf=%b, expected %h ovf=%b uf=%b",
                 i, Result, Overflow_out, Underflow_out, v[i].res, v[i].ovf, v[i].uf);
      end
    end
  endtask

  task automatic test_div;
    vec_t v[6];
    v[0] = '{3'b011, 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0};
    v[1] = '{3'b011, 32'h4000_0000, 32'h0000_0000, 32'h7F80_0000, 1'b0, 1'b0};
    v[2] = '{3'b011, 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0, 1'b0};
    v[3] = '{3'b011, 32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b1};
    v[4] = '{3'b011, 32'hC000_0000, 32'h7F80_0000, 32'h8000_0000, 1'b0, 1'b0};
    v[5] = '{3'b011, 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(v[i].op, v[i].a, v[i].b);
      checks++;
      if (Result !== v[i].res || Overflow_out !== v[i].ovf || Underflow_out !== v[i].uf) begin
        errors++;
        $display("[TB] FAIL div[%0d]: got %h ovf=%b uf=%b, expected %h ovf=%b uf=%b",
                 i, Result, Overflow_out, Underflow_out, v[i].res, v[i].ovf, v[i].uf);
      end
    end
  endtask

  task automatic test_recip;
    vec_t v[7];
    v[0] = '{3'b100, 32'h4000_0000, 32'h1234_5678, 32'h3F00_0000, 1'b0, 1'b0};
    v[1] = '{3'b100, 32'h0000_0000, 32'h4000_0000, 32'h7F80_0000, 1'b0, 1'b0};
    v[2] = '{3'b101, 32'h4000_0000, 32'h4080_0000, 32'h3E80_0000, 1'b0, 1'b0};
    v[3] = '{3'b101, 32'h4000_0000, 32'h7F80_0000, 32'h0000_0000, 1'b0, 1'b0};
    v[4] = '{3'b100, 32'h8000_0000, 32'h0000_0000, 32'hFF80_0000, 1'b0, 1'b0};
    v[5] = '{3'b101, 32'h0000_0000, 32'hFF80_0000, 32'h8000_0000, 1'b0, 1'b0};
    v[6] = '{3'b100, 32'h7F00_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      applyStimulus(v[i].op, v[i].a, v[i].b);
      checks++;
      if (Result !== v[i].res || Overflow_out !== v[i].ovf || Underflow_out !== v[i].uf) begin
        errors++;
        $display("[TB] FAIL recip[%0d]: got %h ovf=%b uf=%b, expected %h ovf=%b uf=%b",
                 i, Result, Overflow_out, Underflow_out, v[i].res, v[i].ovf, v[i].uf);
      end
    end
  endtask

  task automatic test_reserved;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(3'(6 + i), 32'h7F00_0000, 32'h4000_0000);
      checks++;
      if (Result !== 32'd0 || Overflow_out !== 1'b0 || Underflow_out !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reserved[%0d]: got %h ovf=%b uf=%b, expected 00000000 ovf=0 uf=0",
                 i, Result, Overflow_out, Underflow_out);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [33:0] expected;
    logic [2:0]  op;
    logic [31:0] a, b;
    // Operands replaced part-way through a cycle: only the last values before the edge count
    @(negedge clk);
    OpCode = 3'b010;
    A = 32'h7F00_0000;
    B = 32'h4000_0000;
    #2;
    OpCode = 3'b000;
    A = 32'h4000_0000;
    B = 32'h4040_0000;
    @(posedge clk);
    #1;
    checks++;
    if ({Overflow_out, Underflow_out, Result} !== {2'b00, 32'h40A0_0000}) begin
      errors++;
      $display("[TB] FAIL midcycle_change: got %h ovf=%b uf=%b, expected 40a00000 ovf=0 uf=0",
               Result, Overflow_out, Underflow_out);
    end
    applyStimulus(3'b010, 32'h7F00_0000, 32'h4000_0000);
    applyStimulus(3'b000, 32'h4000_0000, 32'h4040_0000);
    checks++;
    if (Overflow_out !== 1'b0 || Result !== 32'h40A0_0000) begin
      errors++;
      $display("[TB] FAIL flag_not_sticky: got %h ovf=%b, expected 40a00000 ovf=0",
               Result, Overflow_out);
    end
    for (int i = 0; i < 200; i++) begin
      op = 3'($urandom_range(0, 5));
      a = randOperand();
      b = randOperand();
      expected = modelOp(op, a, b);
      applyStimulus(op, a, b);
      checks++;
      if ({Overflow_out, Underflow_out, Result} !== expected) begin
        errors++;
        $display("[TB] FAIL stream[%0d] op=%0d a=%h b=%h: got %h ovf=%b uf=%b, expected %h ovf=%b uf=%b",
                 i, op, a, b, Result, Overflow_out, Underflow_out,
                 expected[31:0], expected[33], expected[32]);
      end
    end
  endtask

  task automatic test_reset_concurrent;
    @(negedge clk);
    rst = 1'b0;
    OpCode = 3'b010;
    A = 32'h4000_0000;
    B = 32'h4040_0000;
    @(posedge clk);
    #1;
    checks++;
    if (Result !== 32'd0 || Overflow_out !== 1'b0 || Underflow_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_wins: got %h ovf=%b uf=%b, expected 00000000 ovf=0 uf=0",
               Result, Overflow_out, Underflow_out);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (Result !== 32'h40C0_0000 || Overflow_out !== 1'b0 || Underflow_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL first_after_reset: got %h ovf=%b uf=%b, expected 40c00000 ovf=0 uf=0",
               Result, Overflow_out, Underflow_out);
    end
  endtask

  task automatic test_random;
    logic [33:0] expected;
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 1500; i++) begin
      op = 3'($urandom_range(0, 7));
      a = randOperand();
      b = randOperand();
      // Nearly equal operands exercise cancellation in add/sub
      if (op <= 3'd1 && $urandom_range(0, 2) == 0) begin
        b = a ^ 32'($urandom_range(0, 1023));
        b[31] = 1'($urandom);
        if ($urandom_range(0, 1) == 1 && a[30:23] > 8'd1 && a[30:23] < 8'hFF)
          b[30:23] = a[30:23] - 8'd1;
      end
      expected = modelOp(op, a, b);
      applyStimulus(op, a, b);
      checks++;
      if ({Overflow_out, Underflow_out, Result} !== expected) begin
        errors++;
        $display("[TB] FAIL random[%0d] op=%0d a=%h b=%h: got %h ovf=%b uf=%b, expected %h ovf=%b uf=%b",
                 i, op, a, b, Result, Overflow_out, Underflow_out,
                 expected[31:0], expected[33], expected[32]);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    A = '0;
    B = '0;
    OpCode = 3'b000;
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_div();
    test_recip();
    test_reserved();
    test_back_to_back();
    test_reset_concurrent();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpu_32.md
# fpu_32

Single-precision (IEEE-754 binary32) floating-point unit: add, subtract, multiply, divide, and reciprocal of either operand, selected by a 3-bit opcode. Results and exception flags are registered on one clock. It sits as a leaf execution block behind an operand/opcode source that holds inputs stable until the registered result is consumed.

## Interface
- WIDTH, 32, operand/result width; only 32 is supported.
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  reset; synchronous and active-low.
- A  input  WIDTH  operand A (binary32).
- B  input  WIDTH  operand B (binary32).
- OpCode  input  3  operation select.
- Result  output  WIDTH  registered binary32 result.
- Overflow_out  output  1  registered; result exponent overflowed to ±Inf.
- Underflow_out  output  1  registered; nonzero result flushed to ±0.

## Operation
- OpCode: 000 A+B, 001 A−B, 010 A×B, 011 A÷B, 100 1/A, 101 1/B, 110/111 reserved → Result 0x00000000, flags 0.
- Compute is combinational from A, B, OpCode; Result and flags capture it every rising edge while rst=1.
- Rounding: round-toward-zero (truncate) on all ops.
- Subnormals: inputs with exponent 0 are treated as ±0; outputs below min normal flush to signed zero and set Underflow_out (only if the exact result was nonzero).
- Overflow: biased exponent ≥255 → ±Inf (0x7F800000 | sign), Overflow_out=1.
- NaN output is canonical 0x7FC00000; any NaN input yields it.
- Special cases, add/sub (sub = add with B sign flipped): Inf + finite = that Inf; Inf + Inf same sign = Inf; opposite-sign Infs → NaN; exact zero result = +0.
- Mul: 0×Inf → NaN; Inf×finite nonzero → Inf; sign = sA xor sB; zero operand → signed zero.
- Div: 0/0 → NaN; Inf/Inf → NaN; nonzero/0 → Inf (sign xor), no overflow flag; finite/Inf → signed 0; 0/nonzero → signed 0.
- Reciprocal: 1/±0 → ±Inf; 1/±Inf → ±0; otherwise 1.0÷operand using the divide datapath.
- Special-case results never set flags.
- Mantissa datapath: add aligns with 24-bit significands + guard bits, normalises via leading-zero count; mul 24×24→48-bit product; div restoring divide of 24-bit significands to ≥25 quotient bits.

## Timing
- Reset (rst=0 at an edge): Result=0x00000000, Overflow_out=0, Underflow_out=0; held while rst=0.
- Latency: one cycle; result for inputs stable before edge N is visible after edge N.
- No handshake; output tracks inputs every cycle. Operand/opcode change mid-flight simply replaces next cycle's result.
- Reset asserted concurrently with new inputs: reset wins; first valid result one edge after rst returns to 1.
- Flags are per-result, not sticky.

## Test plan
- Reset: rst=0, A=B=0 for several cycles → Result=0x00000000, both flags 0.
- Add: 0x40000000+0x40400000 → 0x40A00000; 0x7F800000+0x40400000 → 0x7F800000; 0xFF800000+0x7F800000 → 0x7FC00000.
- Sub: 0x40A00000−0x40400000 → 0x40000000; 0x7F800000−0x7F800000 → 0x7FC00000.
- Mul: 0x40000000×0x40400000 → 0x40C00000; 0x00000000×0x7F800000 → 0x7FC00000; 0x7F000000×0x40000000 → 0x7F800000 with Overflow_out=1.
- Div: 0x40C00000÷0x40000000 → 0x40400000; 0x40000000÷0 → 0x7F800000; 0÷0 → 0x7FC00000; 0x00800000÷0x40000000 → 0x00000000 with Underflow_out=1.
- Reciprocal: op 100 A=0x40000000 → 0x3F000000; A=0 → 0x7F800000; op 101 B=0x40800000 → 0x3E800000; B=0x7F800000 → 0x00000000.
